fpu_sched: RTL

- Round-robin scheduler that shares one multi-cycle fpu instance between NREQ requesters.
- Arbitrates requests, latches operands, and issues a one-cycle start pulse to the fpu.
- Waits for the fpu's finish, then returns the result to the granted requester as a one-cycle response.
- Sits between the fpu and its clients, such as the CPU issue stage and DMA-side math units.

---
 rtl/fpu_sched.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fpu_sched.sv
// ---------------------------------------------------------------------------
// fpu_sched
//   Round-robin scheduler that shares a single multi-cycle FPU between NREQ
//   requesters. One operation is in flight at a time:
//     IDLE  -> grant the next valid requester after the last grant, latch its
//              funct/a/b onto the FPU operand registers
//     ISSUE -> one-cycle fpu_start pulse
//     WAIT  -> wait for fpu_finish (or the optional watchdog), capture result
//     RESP  -> one-cycle rsp_valid to the granted requester, count completion
//
// Parameters
//   NREQ     number of requesters (2..8)
//   TIMEOUT  watchdog limit in WAIT cycles (only with FPU_SCHED_TIMEOUT_EN)
//
// Configuration macro
//   FPU_SCHED_TIMEOUT_EN  enables the WAIT watchdog; on expiry the response
//                         is qNaN (32'h7FC00000) with rsp_err = 1.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid[NREQ]            per-requester request valid
//   req_funct[2*NREQ]          packed funct, requester i at [2i+1:2i]
//   req_a/req_b[32*NREQ]       packed operands, requester i at [32i+31:32i]
//   req_ready[NREQ]            one-hot acceptance (combinational, IDLE only)
//   rsp_valid[NREQ]            one-hot one-cycle result strobe
//   rsp_o[32], rsp_err         result and timeout flag
//   busy                       high in any state but IDLE
//   fpu_funct/fpu_a/fpu_b      operands to the FPU, stable ISSUE..RESP
//   fpu_start                  one-cycle issue pulse
//   fpu_o, fpu_finish          FPU result and completion (sampled in WAIT)
//   done_count[16]             completed operations, wrapping
// ---------------------------------------------------------------------------
module fpu_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_funct,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_o,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [1:0]           fpu_funct,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    output logic                 fpu_start,
    input  logic [31:0]          fpu_o,
    input  logic                 fpu_finish,
    output logic [15:0]          done_count
);

    localparam int          PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR   = NREQ;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [1:0]      r_funct;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [31:0]     r_rsp;
    logic [15:0]     r_done;

    logic            w_found;
    logic [PW-1:0]   w_gidx;
    logic            w_timeout;

    // Round-robin search starting just after the last grant.
    always_comb begin
        logic [PW-1:0] cand;
        w_found = 1'b0;
        w_gidx  = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = PW'((32'(r_ptr) + k) % NR);
            if (!w_found && req_valid[cand]) begin
                w_found = 1'b1;
                w_gidx  = cand;
            end
        end
    end

`ifdef FPU_SCHED_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] r_wcnt;
    logic          r_err;

    // Counter is cleared while in ISSUE so it reads 0 on the first WAIT
    // cycle; the TIMEOUT-th WAIT cycle sees TIMEOUT-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wcnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (r_state == S_WAIT) begin
                if (fpu_finish) begin
                    r_err <= 1'b0;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_wcnt == CW'(TIMEOUT - 1));
    assign rsp_err   = r_err && (r_state == S_RESP);
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;

    // TIMEOUT only shapes the watchdog; keep it referenced in this build.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= PW'(NREQ - 1);
            r_funct <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rsp   <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ptr   <= w_gidx;
                        r_funct <= req_funct[2*w_gidx +: 2];
                        r_a     <= req_a[32*w_gidx +: 32];
                        r_b     <= req_b[32*w_gidx +: 32];
                    end
                end
                S_WAIT: begin
                    // A finish coinciding with the watchdog wins.
                    if (fpu_finish) begin
                        r_rsp <= fpu_o;
                    end else if (w_timeout) begin
                        r_rsp <= QNAN;
                    end
                end
                S_RESP: begin
                    r_done <= r_done + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (fpu_finish || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (r_state == S_IDLE && w_found) begin
            req_ready[w_gidx] = 1'b1;
        end
        if (r_state == S_RESP) begin
            rsp_valid[r_ptr] = 1'b1;
        end
    end

    assign fpu_start  = (r_state == S_ISSUE);
    assign busy       = (r_state != S_IDLE);
    assign fpu_funct  = r_funct;
    assign fpu_a      = r_a;
    assign fpu_b      = r_b;
    assign rsp_o      = r_rsp;
    assign done_count = r_done;

endmodule
